// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time program loader.
// Holds the loader state encoding and the default word limit.
package loader_pkg;

    typedef enum logic [1:0] {
        HDR,
        DATA,
        DONE,
        ERROR
    } loaderState_e;

    localparam int DEFAULT_MAX_WORDS = 256;
    localparam int BYTE_POS_W        = 2;

endpackage

// File: rtl/byte_assembler.sv
// Packs a big-endian byte stream into 32-bit words and flags the cycle in
// which the fourth byte of a word is accepted.
module byte_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byteIn,
    output logic [31:0] word,
    output logic        wordDone
);

    logic [BYTE_POS_W-1:0] pos;
    logic [23:0]           shiftQ;

    // The completed word includes the byte being accepted this cycle, so the
    // owner can register it on the same edge without an extra stage.
    assign word     = {shiftQ, byteIn};
    assign wordDone = accept && (pos == '1);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst || clear) begin
            pos    <= '0;
            shiftQ <= '0;
        end else if (accept) begin
            pos    <= pos + 1'b1;
            shiftQ <= {shiftQ[15:0], byteIn};
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a length-prefixed program into instruction memory while holding the
// CPU, then releases it; oversize headers park the loader in an error drain.
module prog_loader
    import loader_pkg::*;
#(
    parameter int          MAX_WORDS = DEFAULT_MAX_WORDS,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    input  logic        restart,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] words_loaded
);

    loaderState_e state;
    logic         wrEnQ;
    logic         holdQ;
    logic         doneQ;
    logic         errorQ;
    logic [31:0]  addrQ;
    logic [31:0]  dataQ;
    logic [31:0]  wordsLeft;
    logic [15:0]  loadedQ;

    logic         accept;
    logic         rearm;
    logic         wordDone;
    logic [31:0]  word;

    assign in_ready = ~rst & (state != DONE);
    assign accept   = in_valid & in_ready;
    assign rearm    = restart & ((state == DONE) || (state == ERROR));

    byte_assembler u_byteAssembler (
        .clk      (clk),
        .rst      (rst),
        .clear    (rearm),
        .accept   (accept),
        .byteIn   (in_data),
        .word     (word),
        .wordDone (wordDone)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR;
            wrEnQ     <= 1'b0;
            holdQ     <= 1'b1;
            doneQ     <= 1'b0;
            errorQ    <= 1'b0;
            addrQ     <= BASE_ADDR;
            dataQ     <= '0;
            wordsLeft <= '0;
            loadedQ   <= '0;
        end else begin
            wrEnQ <= 1'b0;
            if (wrEnQ) begin
                addrQ <= addrQ + 32'd4;
            end

            unique case (state)
                HDR: begin
                    if (wordDone) begin
                        if (word == 32'd0) begin
                            state <= DONE;
                        end else if (word > 32'(MAX_WORDS)) begin
                            state  <= ERROR;
                            errorQ <= 1'b1;
                        end else begin
                            state     <= DATA;
                            wordsLeft <= word;
                        end
                    end
                end

                DATA: begin
                    if (wordDone) begin
                        wrEnQ     <= 1'b1;
                        dataQ     <= word;
                        loadedQ   <= loadedQ + 16'd1;
                        wordsLeft <= wordsLeft - 32'd1;
                        if (wordsLeft == 32'd1) begin
                            state <= DONE;
                        end
                    end
                end

                DONE, ERROR: begin
                    // Re-arming overrides the pending address step of a final write.
                    if (restart) begin
                        state   <= HDR;
                        holdQ   <= 1'b1;
                        doneQ   <= 1'b0;
                        errorQ  <= 1'b0;
                        addrQ   <= BASE_ADDR;
                        loadedQ <= '0;
                    end else if (state == DONE) begin
                        doneQ <= 1'b1;
                        holdQ <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign wr_en        = wrEnQ;
    assign wr_addr      = addrQ;
    assign wr_data      = dataQ;
    assign cpu_hold     = holdQ;
    assign done         = doneQ;
    assign error        = errorQ;
    assign words_loaded = loadedQ;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter MAX_WORDS, default 256, max instruction words accepted per load.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of first written word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  byte-stream source has a byte on in_data.
REQ-006 in_data  input  8  program byte; stream is big-endian, MSB byte first.
REQ-007 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid & in_ready.
REQ-008 restart  input  1  one-cycle pulse re-arms the loader from DONE or ERROR.
REQ-009 wr_en  output  1  one-cycle write strobe to instruction memory.
REQ-010 wr_addr  output  32  byte address of the write; word aligned.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the CPU program counter/fetch while high.
REQ-013 done  output  1  level; program fully loaded.
REQ-014 error  output  1  level; header word count exceeded MAX_WORDS.
REQ-015 words_loaded  output  16  count of words written in the current load.

Function
REQ-016 States SHALL be HDR, DATA, DONE, ERROR.
REQ-017 HDR: in_ready=1; 4 accepted bytes form word count N (first byte = N[31:24]).
REQ-018 On 4th header byte: N==0 -> DONE; N>MAX_WORDS -> ERROR; else -> DATA with remaining count N.
REQ-019 DATA: in_ready=1; every 4 accepted bytes form one word, first byte in wr_data[31:24].
REQ-020 wr_en SHALL pulse exactly one cycle after the 4th byte of a word is accepted, with wr_data holding that word.
REQ-021 wr_addr SHALL equal BASE_ADDR for the first word and increment by 4 after each wr_en; words_loaded increments in the wr_en cycle.
REQ-022 Accepting bytes SHALL continue without stall during the wr_en cycle (one byte per cycle sustained).
REQ-023 Cycles with in_valid=0 SHALL not alter byte position, count, or outputs other than clearing wr_en.
REQ-024 After the wr_en of word N the FSM enters DONE; done=1 and cpu_hold=0 from the following cycle.
REQ-025 DONE: in_ready=0, no writes, done=1, cpu_hold=0.
REQ-026 ERROR: error=1, cpu_hold=1, in_ready=1 (bytes drained and discarded), wr_en never asserted.
REQ-027 restart in DONE or ERROR -> HDR next cycle: done=0, error=0, cpu_hold=1, words_loaded=0, wr_addr=BASE_ADDR, byte position 0.
REQ-028 restart in HDR or DATA SHALL be ignored.
REQ-029 restart coincident with in_valid in DONE: restart takes effect, byte not consumed (in_ready=0 that cycle).
REQ-030 Byte position counter is 2 bits and wraps 3->0 on each completed word.

Reset
REQ-031 While rst=1: state=HDR, in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0, cpu_hold=1, done=0, error=0, words_loaded=0, byte position 0.
REQ-032 rst mid-load SHALL discard any partial word and the header; no wr_en in the cycle following rst.
REQ-033 rst overrides restart and in_valid in the same cycle.

Structure
REQ-034 Package loader_pkg SHALL hold the state enumeration, default MAX_WORDS, and byte-position width.
REQ-035 Sub-module byte_assembler SHALL shift in bytes and flag word completion; FSM, counters and address in prog_loader.
REQ-036 prog_loader SHALL drive the instruction memory write port and the CPU hold input; no combinational path from in_valid to wr_en.

Verification
REQ-037 Stream 00 00 00 02, 20 08 00 05, 8C 09 00 04 back-to-back -> wr_en at addr 0 data 32'h20080005, at addr 4 data 32'h8C090004; done=1, cpu_hold=0 next cycle; words_loaded=2.
REQ-038 Header 00 00 00 00 -> DONE immediately, no wr_en, words_loaded=0.
REQ-039 Header 00 00 01 01 (257) with MAX_WORDS=256 -> error=1, cpu_hold=1, 8 further bytes accepted, no wr_en; restart -> HDR, error=0.
REQ-040 Same stream as REQ-037 with in_valid low every other cycle -> identical writes, only timing stretched.
REQ-041 rst asserted after 6 bytes of a 2-word load, then full 1-word load 00 00 00 01 AA BB CC DD -> single write 32'hAABBCCDD at addr 0.
REQ-042 In DONE, restart and in_valid same cycle -> byte not consumed; next load starts at wr_addr 0.
